// File: rtl/riscv_memory_arbiter.sv
// riscv_memory_arbiter: shares one memory port between an instruction cache
// (port 0) and a data cache (port 1), with one transaction outstanding at a time.
// Port 1 wins ties by default. Each port has a starve counter, and a port whose
// counter reaches STARVE_LIMIT wins the next arbitration. If both ports are at
// the limit, port 0 wins.
// Optional macro RISCV_ARBITER_ROUND_ROBIN_EN replaces fixed priority with a
// last-winner register. On a tie, the port that did not win last gets the grant.
module riscv_memory_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] p0_address,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [31:0] p0_out,
  output logic [31:0] p0_in,
  output logic        p0_ready,
  output logic [31:0] p0_address_requested,
  input  logic [31:0] p1_address,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [31:0] p1_out,
  output logic [31:0] p1_in,
  output logic        p1_ready,
  output logic [31:0] p1_address_requested,
  output logic [31:0] memory_address,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] memory_out,
  input  logic [31:0] memory_in,
  input  logic        memory_ready,
  input  logic [31:0] memory_address_requested
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_starve0;
  logic [7:0] r_starve1;
  logic       w_req0, w_req1;
  logic       w_pend0, w_pend1;
  logic       w_arb;
  logic       w_done0, w_done1;
  logic       w_force0, w_force1;
  logic       w_grant0, w_grant1;

  // Saturating starve count: cleared on grant or when the port is not waiting.
  function automatic logic [7:0] starve_next(input logic pend, input logic grant,
                                             input logic [7:0] cnt);
    if (!pend || grant) return 8'd0;
    else if (cnt >= LIMIT) return LIMIT;
    else return cnt + 8'd1;
  endfunction

  assign w_req0 = p0_read | p0_write;
  assign w_req1 = p1_read | p1_write;
  // The owner's held request is never pending. This also excludes the owner in
  // its own completion cycle.
  assign w_pend0  = w_req0 && (r_state != BUSY0);
  assign w_pend1  = w_req1 && (r_state != BUSY1);
  // Gating with reset keeps every output at 0 while reset is asserted.
  assign w_arb    = reset && ((r_state == IDLE) || memory_ready);
  assign w_done0  = reset && (r_state == BUSY0) && memory_ready;
  assign w_done1  = reset && (r_state == BUSY1) && memory_ready;
  assign w_force0 = w_pend0 && (r_starve0 >= LIMIT);
  assign w_force1 = w_pend1 && (r_starve1 >= LIMIT);

`ifdef RISCV_ARBITER_ROUND_ROBIN_EN
  logic r_last;  // 1 when port 1 won the most recent grant

  // Remember the last winner so that ties alternate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_last <= 1'b1;
    else if (w_grant0 || w_grant1) r_last <= w_grant1;
  end
`endif

  // Grant selection: starve override first, then the tie rule.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_arb) begin
      if (w_force0) w_grant0 = 1'b1;
      else if (w_force1) w_grant1 = 1'b1;
      else if (w_pend0 && w_pend1) begin
`ifdef RISCV_ARBITER_ROUND_ROBIN_EN
        if (r_last) w_grant0 = 1'b1;
        else w_grant1 = 1'b1;
`else
        w_grant1 = 1'b1;
`endif
      end
      else if (w_pend1) w_grant1 = 1'b1;
      else if (w_pend0) w_grant0 = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next_state;
  end

  // Next state, one-cycle issue strobes and response routing.
  always_comb begin
    w_next_state         = r_state;
    memory_address       = 32'd0;
    memory_out           = 32'd0;
    memory_read          = 1'b0;
    memory_write         = 1'b0;
    p0_ready             = w_done0;
    p1_ready             = w_done1;
    p0_in                = 32'd0;
    p1_in                = 32'd0;
    p0_address_requested = 32'd0;
    p1_address_requested = 32'd0;
    if (w_done0) begin
      p0_in                = memory_in;
      p0_address_requested = memory_address_requested;
    end
    if (w_done1) begin
      p1_in                = memory_in;
      p1_address_requested = memory_address_requested;
    end
    if (w_grant0) begin
      w_next_state   = BUSY0;
      memory_address = p0_address;
      memory_out     = p0_out;
      memory_write   = p0_write;
      memory_read    = p0_read && !p0_write;
    end else if (w_grant1) begin
      w_next_state   = BUSY1;
      memory_address = p1_address;
      memory_out     = p1_out;
      memory_write   = p1_write;
      memory_read    = p1_read && !p1_write;
    end else if (w_done0 || w_done1) begin
      w_next_state = IDLE;
    end
  end

  // Starve counters for both ports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve0 <= 8'd0;
      r_starve1 <= 8'd0;
    end else begin
      r_starve0 <= starve_next(w_pend0, w_grant0, r_starve0);
      r_starve1 <= starve_next(w_pend1, w_grant1, r_starve1);
    end
  end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Testbench for riscv_memory_arbiter. The caches, the memory and the expected
// arbitration behaviour are modelled at transaction level. Responses expected
// per port are queued when a request starts and popped when the port sees ready.
module tb_riscv_memory_arbiter;

  localparam int LIM = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] p0_address = '0, p1_address = '0, p0_out = '0, p1_out = '0;
  logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [31:0] p0_in, p1_in, p0_address_requested, p1_address_requested;
  logic        p0_ready, p1_ready;
  logic [31:0] memory_address, memory_out;
  logic        memory_read, memory_write;
  logic [31:0] memory_in = '0, memory_address_requested = '0;
  logic        memory_ready = 1'b0;

  riscv_memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write), .p0_out(p0_out),
    .p0_in(p0_in), .p0_ready(p0_ready), .p0_address_requested(p0_address_requested),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write), .p1_out(p1_out),
    .p1_in(p1_in), .p1_ready(p1_ready), .p1_address_requested(p1_address_requested),
    .memory_address(memory_address), .memory_read(memory_read),
    .memory_write(memory_write), .memory_out(memory_out), .memory_in(memory_in),
    .memory_ready(memory_ready), .memory_address_requested(memory_address_requested)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  // Model state.
  int          m_owner = -1;
  int          m_cnt[2] = '{0, 0};
  int          m_last = 1;
  logic        mon_issue = 1'b0;
  logic [31:0] mon_issue_addr = '0;
  logic        mon_rdy[2] = '{1'b0, 1'b0};

  // Stimulus state.
  logic        act[2] = '{1'b0, 1'b0};
  logic        rand_en = 1'b0, spur_en = 1'b0, mem_busy = 1'b0;
  int          lat_fixed = 1, mem_left = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic set_port(input int n, input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr);
    if (n == 0) begin p0_address = a; p0_out = d; p0_read = rd; p0_write = wr; end
    else begin p1_address = a; p1_out = d; p1_read = rd; p1_write = wr; end
  endtask

  // op: 0 read, 1 write, 2 both bits set (treated as a write)
  task automatic start_req(input int n, input logic [31:0] a, input logic [31:0] d, input int op);
    act[n] = 1'b1;
    set_port(n, a, d, op != 1, op != 0);
    if (n == 0) exp_q0.push_back({a, hash(a)});
    else exp_q1.push_back({a, hash(a)});
  endtask

  // One cycle of cache and memory behaviour, applied just after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    for (int n = 0; n < 2; n++)
      if (act[n] && mon_rdy[n]) begin
        act[n] = 1'b0;
        set_port(n, '0, '0, 1'b0, 1'b0);
      end
    memory_ready = 1'b0;
    memory_in = $urandom;
    memory_address_requested = $urandom;
    if (mon_issue) begin
      mem_busy = 1'b1;
      mem_left = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      mem_addr = mon_issue_addr;
    end
    if (mem_busy) begin
      mem_left--;
      if (mem_left == 0) begin
        memory_ready = 1'b1;
        memory_in = hash(mem_addr);
        memory_address_requested = mem_addr;
        mem_busy = 1'b0;
      end
    end else if (spur_en && ($urandom % 6 == 0)) begin
      memory_ready = 1'b1;
    end
    if (rand_en)
      for (int n = 0; n < 2; n++)
        if (!act[n] && ($urandom % 3 == 0))
          start_req(n, $urandom, $urandom, int'($urandom % 3));
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Reference check at the falling edge: derive the expected grant, strobes and
  // response routing from the arbitration rules, then advance the model.
  always @(negedge clock) begin : monitor
    logic req[2];
    logic pend[2];
    logic arb, comp, exp_rdy;
    logic [31:0] wa, wd;
    logic wrd, wwr;
    logic [63:0] e;
    int win;
    if (!reset) begin
      chk("rst_mem_read", {31'd0, memory_read}, 32'd0);
      chk("rst_mem_write", {31'd0, memory_write}, 32'd0);
      chk("rst_mem_address", memory_address, 32'd0);
      chk("rst_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
      chk("rst_p_in", p0_in | p1_in | p0_address_requested | p1_address_requested, 32'd0);
      m_owner = -1; m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
      mon_issue = 1'b0; mon_rdy[0] = 1'b0; mon_rdy[1] = 1'b0;
    end else begin
      req[0] = p0_read | p0_write;
      req[1] = p1_read | p1_write;
      comp = (m_owner >= 0) && memory_ready;
      arb  = (m_owner < 0) || memory_ready;
      for (int n = 0; n < 2; n++) pend[n] = req[n] && (m_owner != n);
      win = -1;
      if (arb) begin
        if (pend[0] && m_cnt[0] >= LIM) win = 0;
        else if (pend[1] && m_cnt[1] >= LIM) win = 1;
        else if (pend[0] && pend[1]) begin
`ifdef RISCV_ARBITER_ROUND_ROBIN_EN
          win = (m_last == 1) ? 0 : 1;
`else
          win = 1;
`endif
        end
        else if (pend[1]) win = 1;
        else if (pend[0]) win = 0;
      end
      wa  = (win == 0) ? p0_address : p1_address;
      wd  = (win == 0) ? p0_out : p1_out;
      wrd = (win == 0) ? p0_read : p1_read;
      wwr = (win == 0) ? p0_write : p1_write;
      chk("memory_read", {31'd0, memory_read}, {31'd0, (win >= 0) && wrd && !wwr});
      chk("memory_write", {31'd0, memory_write}, {31'd0, (win >= 0) && wwr});
      if (win >= 0) begin
        chk("memory_address", memory_address, wa);
        if (wwr) chk("memory_out", memory_out, wd);
      end
      for (int n = 0; n < 2; n++) begin
        exp_rdy = comp && (m_owner == n);
        mon_rdy[n] = exp_rdy;
        chk(n == 0 ? "p0_ready" : "p1_ready", {31'd0, n == 0 ? p0_ready : p1_ready},
            {31'd0, exp_rdy});
        if (exp_rdy) begin
          chk(n == 0 ? "p0_in_route" : "p1_in_route", n == 0 ? p0_in : p1_in, memory_in);
          if ((n == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk(n == 0 ? "p0_addr_req" : "p1_addr_req",
                n == 0 ? p0_address_requested : p1_address_requested, e[63:32]);
            chk(n == 0 ? "p0_data" : "p1_data", n == 0 ? p0_in : p1_in, e[31:0]);
          end
        end else begin
          chk(n == 0 ? "p0_idle_outs" : "p1_idle_outs",
              n == 0 ? (p0_in | p0_address_requested) : (p1_in | p1_address_requested), 32'd0);
        end
      end
      for (int n = 0; n < 2; n++)
        m_cnt[n] = (!pend[n] || win == n) ? 0 : ((m_cnt[n] + 1 > LIM) ? LIM : m_cnt[n] + 1);
      if (win >= 0) begin m_owner = win; m_last = win; end
      else if (comp) m_owner = -1;
      mon_issue = (win >= 0);
      mon_issue_addr = wa;
    end
  end

  initial begin
    steps(2);
    #1 reset = 1'b1;
    steps(1);

    // Idle single read, one-cycle memory latency.
    lat_fixed = 1;
    start_req(0, 32'h100, 32'h0, 0);
    steps(4);

    // Contention: read on port 0 and write on port 1 rise together.
    start_req(0, 32'h100, 32'h0, 0);
    start_req(1, 32'h200, 32'h12345678, 1);
    steps(6);

    // Spurious memory_ready while idle with no requests.
    memory_ready = 1'b1;
    memory_in = 32'hBAD0BAD0;
    memory_address_requested = 32'h55;
    steps(2);

    // Variable latency with the other port stalled, and both bits set on one.
    lat_fixed = 5;
    start_req(1, 32'h300, 32'hA5A5A5A5, 2);
    steps(1);
    start_req(0, 32'h304, 32'h0, 0);
    steps(16);

    // Reset while port 1 is outstanding, then a late memory_ready.
    start_req(1, 32'h400, 32'h0, 0);
    steps(2);
    reset = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    set_port(0, '0, '0, 1'b0, 1'b0);
    set_port(1, '0, '0, 1'b0, 1'b0);
    exp_q0.delete(); exp_q1.delete();
    mem_busy = 1'b0;
    steps(1);
    reset = 1'b1;
    memory_ready = 1'b1;
    memory_in = hash(32'h400);
    memory_address_requested = 32'h400;
    steps(1);
    lat_fixed = 1;
    start_req(0, 32'h500, 32'h0, 0);
    steps(4);

    // Randomized traffic with random latency and spurious ready pulses.
    lat_fixed = 0;
    spur_en = 1'b1;
    rand_en = 1'b1;
    steps(3000);
    rand_en = 1'b0;
    spur_en = 1'b0;
    steps(40);
    chk("sb_drain_p0", exp_q0.size(), 32'd0);
    chk("sb_drain_p1", exp_q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
